// File: rtl/fano_depuncturer_if.sv
// ---------------------------------------------------------------------------
// fano_depuncturer_if
// Stream bundle between the symbol source and the depuncturer, and between
// the depuncturer and the Fano decoder.
//
// Signals:
//   i_vld        symbol strobe into the depuncturer (gaps allowed)
//   i_data       received coded symbol, SOFT_W bits
//   o_vld        rebuilt pair strobe, one-cycle pulse
//   o_data       {X,Y}, X in the upper SOFT_W bits
//   o_erase      [1]=X erased, [0]=Y erased
//   o_pat_start  marks the first pair of each puncture period
//
// Handshake: strobe-only. A symbol is taken on every clock edge where
// i_vld=1, and a pair is valid on every edge where o_vld=1. There is no
// ready signal and no backpressure in either direction.
//
// Modports:
//   master  symbol source / pair consumer (drives i_*, observes o_*)
//   slave   the depuncturer (observes i_*, drives o_*)
// ---------------------------------------------------------------------------
interface fano_depuncturer_if #(
  parameter int SOFT_W = 1
);
  logic                  i_vld;
  logic [SOFT_W-1:0]     i_data;
  logic                  o_vld;
  logic [2*SOFT_W-1:0]   o_data;
  logic [1:0]            o_erase;
  logic                  o_pat_start;

  modport master (
    output i_vld, i_data,
    input  o_vld, o_data, o_erase, o_pat_start
  );

  modport slave (
    input  i_vld, i_data,
    output o_vld, o_data, o_erase, o_pat_start
  );
endinterface

// File: rtl/fano_depuncturer.sv
// ---------------------------------------------------------------------------
// fano_depuncturer
// Rebuilds rate-1/2 mother-code (X,Y) pairs from a serial stream of received
// symbols. Punctured positions are filled with zero data and flagged in
// o_erase. Supported rates are 1/2, 2/3, 3/4 and 7/8, selected at run time.
// A slip request from the decoder drops one symbol to shift the puncture
// alignment during sync search.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   i_code_rate  0=1/2, 1=2/3, 2=3/4, 3=7/8
//   i_shift_phs  one-cycle slip request
//   bus          fano_depuncturer_if.slave (i_vld/i_data in, pairs out)
//   o_slip_cnt   executed-slip count, saturating at 255
//                (only when FANO_DEPUNCT_SLIP_CNT_EN is defined)
//
// Optional feature macro: FANO_DEPUNCT_SLIP_CNT_EN
// ---------------------------------------------------------------------------
module fano_depuncturer #(
  parameter int SOFT_W  = 1,
  parameter int MAX_PAT = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           i_code_rate,
  input  logic                 i_shift_phs,
  fano_depuncturer_if.slave    bus
`ifdef FANO_DEPUNCT_SLIP_CNT_EN
  ,
  output logic [7:0]           o_slip_cnt
`endif
);

  localparam int PTR_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

  typedef enum logic {
    SLOT_X = 1'b0,
    SLOT_Y = 1'b1
  } slot_t;

  // Puncture tables. Bit p holds the sent flag of pair p (1 = transmitted).
  function automatic logic [MAX_PAT-1:0] pat_x(input logic [1:0] r);
    case (r)
      2'd0:    return MAX_PAT'(7'b0000001);
      2'd1:    return MAX_PAT'(7'b0000001);
      2'd2:    return MAX_PAT'(7'b0000101);
      default: return MAX_PAT'(7'b1010001);
    endcase
  endfunction

  function automatic logic [MAX_PAT-1:0] pat_y(input logic [1:0] r);
    case (r)
      2'd0:    return MAX_PAT'(7'b0000001);
      2'd1:    return MAX_PAT'(7'b0000011);
      2'd2:    return MAX_PAT'(7'b0000011);
      default: return MAX_PAT'(7'b0101111);
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] last_pair(input logic [1:0] r);
    case (r)
      2'd0:    return PTR_W'(0);
      2'd1:    return PTR_W'(1);
      2'd2:    return PTR_W'(2);
      default: return PTR_W'(6);
    endcase
  endfunction

  // Registered state
  logic [1:0]        rate_q;
  logic [PTR_W-1:0]  ptr_q;
  slot_t             slot_q;
  logic [SOFT_W-1:0] x_buf_q;
  logic              pend_q;

  // Combinational next-state
  logic              rate_chg;
  logic [PTR_W-1:0]  ptr_c;
  slot_t             slot_c;
  logic [SOFT_W-1:0] x_buf_c;
  logic              pend_c;
  logic [MAX_PAT-1:0] px;
  logic [MAX_PAT-1:0] py;
  logic              x_sent;
  logic              y_sent;
  logic              discard;
  logic              accept;
  logic              complete;
  logic [PTR_W-1:0]  ptr_nx;
  logic [PTR_W-1:0]  ptr_d;
  slot_t             slot_d;
  logic [SOFT_W-1:0] x_buf_d;
  logic              pend_d;
  logic [SOFT_W-1:0] x_field;
  logic [SOFT_W-1:0] y_field;
  logic [1:0]        erase_d;

  always_comb begin
    rate_chg = (i_code_rate != rate_q);

    // A rate change behaves as if the pointer had already been reset, so a
    // symbol arriving in the same cycle lands in pair 0 / X of the new rate.
    ptr_c   = rate_chg ? '0     : ptr_q;
    slot_c  = rate_chg ? SLOT_X : slot_q;
    x_buf_c = rate_chg ? '0     : x_buf_q;
    pend_c  = rate_chg ? 1'b0   : pend_q;

    px     = pat_x(i_code_rate);
    py     = pat_y(i_code_rate);
    x_sent = px[ptr_c];
    y_sent = py[ptr_c];

    // A request in the same cycle as a symbol slips that very symbol.
    discard = bus.i_vld & (pend_c | i_shift_phs);
    accept  = bus.i_vld & ~discard;
    pend_d  = discard ? 1'b0 : (pend_c | i_shift_phs);

    // The pair closes on its Y slot, or on X when Y is punctured.
    complete = accept & ((slot_c == SLOT_Y) | ~y_sent);

    ptr_nx = (ptr_c == last_pair(i_code_rate)) ? '0 : ptr_c + PTR_W'(1);

    ptr_d   = ptr_c;
    slot_d  = slot_c;
    x_buf_d = x_buf_c;
    if (accept) begin
      if (complete) begin
        // Skip straight to Y of the next pair when its X is punctured.
        ptr_d   = ptr_nx;
        slot_d  = px[ptr_nx] ? SLOT_X : SLOT_Y;
        x_buf_d = '0;
      end else begin
        slot_d  = SLOT_Y;
        x_buf_d = bus.i_data;
      end
    end

    if (slot_c == SLOT_Y) begin
      x_field = x_sent ? x_buf_c : '0;
      y_field = bus.i_data;
      erase_d = {~x_sent, 1'b0};
    end else begin
      x_field = bus.i_data;
      y_field = '0;
      erase_d = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_q          <= 2'd0;
      ptr_q           <= '0;
      slot_q          <= SLOT_X;
      x_buf_q         <= '0;
      pend_q          <= 1'b0;
      bus.o_vld       <= 1'b0;
      bus.o_data      <= '0;
      bus.o_erase     <= 2'b00;
      bus.o_pat_start <= 1'b0;
    end else begin
      rate_q          <= i_code_rate;
      ptr_q           <= ptr_d;
      slot_q          <= slot_d;
      x_buf_q         <= x_buf_d;
      pend_q          <= pend_d;
      bus.o_vld       <= complete;
      bus.o_pat_start <= complete & (ptr_c == '0);
      if (complete) begin
        bus.o_data  <= {x_field, y_field};
        bus.o_erase <= erase_d;
      end
    end
  end

`ifdef FANO_DEPUNCT_SLIP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_slip_cnt <= 8'd0;
    end else if (rate_chg) begin
      o_slip_cnt <= {7'd0, discard};
    end else if (discard && (o_slip_cnt != 8'hFF)) begin
      o_slip_cnt <= o_slip_cnt + 8'd1;
    end
  end
`endif

endmodule
